// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - producer result bus and register-file write-port bundle for wb_port_arbiter
interface wb_port_arbiter_if;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [95:0] src_tag;
    logic [14:0] src_reg;
    logic [95:0] src_data;
    logic        WE1;
    logic [4:0]  WriteReg1;
    logic [31:0] ResultW1;
    logic        WE2;
    logic [4:0]  WriteReg2;
    logic [31:0] ResultW2;

    modport master (
        output src_valid, src_tag, src_reg, src_data,
        input  src_ready, WE1, WriteReg1, ResultW1, WE2, WriteReg2, ResultW2
    );

    modport slave (
        input  src_valid, src_tag, src_reg, src_data,
        output src_ready, WE1, WriteReg1, ResultW1, WE2, WriteReg2, ResultW2
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - three-source write-back arbiter onto two register-file ports (optional bypass: WBARB_BYPASS_EN)
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    wb_port_arbiter_if.slave bus,
    output logic             busy
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] tag;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t            mem    [NSRC][DEPTH];
    logic [PW-1:0]   wr_ptr [NSRC];
    logic [PW-1:0]   rd_ptr [NSRC];
    logic [PW:0]     count  [NSRC];
    logic [1:0]      rr_ptr;

    ent_t            in_ent [NSRC];
    ent_t            cand   [NSRC];
    logic [NSRC-1:0] cand_v;
    logic [NSRC-1:0] cand_byp;
    logic [NSRC-1:0] nonempty;
    logic [NSRC-1:0] ready;
    logic [NSRC-1:0] gnt;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;

    logic [1:0]      scan [3];
    logic            a_v, b_v;
    logic [1:0]      a, b;
    logic            a_older, same_reg;
    logic            p1_v, p2_v;
    logic [1:0]      p1, p2, last;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Candidate per source: FIFO head, or the incoming result when bypass is built in
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            in_ent[s].tag  = bus.src_tag[s*32 +: 32];
            in_ent[s].rd   = bus.src_reg[s*5 +: 5];
            in_ent[s].data = bus.src_data[s*32 +: 32];
            nonempty[s]    = (count[s] != '0);
            ready[s]       = (count[s] < (PW+1)'(DEPTH));
            cand[s]        = mem[s][rd_ptr[s]];
            cand_v[s]      = nonempty[s];
            cand_byp[s]    = 1'b0;
`ifdef WBARB_BYPASS_EN
            if (!nonempty[s] && bus.src_valid[s] && !flush) begin
                cand[s]     = in_ent[s];
                cand_v[s]   = 1'b1;
                cand_byp[s] = 1'b1;
            end
`endif
        end
    end

    assign bus.src_ready = ready;
    assign busy          = |nonempty;

    assign scan[0] = rr_ptr;
    assign scan[1] = inc3(rr_ptr);
    assign scan[2] = inc3(inc3(rr_ptr));

    always_comb begin
        a_v = 1'b0;
        b_v = 1'b0;
        a   = 2'd0;
        b   = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            if (cand_v[scan[k]]) begin
                if (!a_v) begin
                    a_v = 1'b1;
                    a   = scan[k];
                end else if (!b_v) begin
                    b_v = 1'b1;
                    b   = scan[k];
                end
            end
        end
    end

    // Same non-zero destination: only the older of the two may write this cycle
    always_comb begin
        gnt      = '0;
        p1_v     = 1'b0;
        p2_v     = 1'b0;
        p1       = a;
        p2       = b;
        last     = a;
        a_older  = (cand[a].tag < cand[b].tag);
        same_reg = (cand[a].rd == cand[b].rd) && (cand[a].rd != 5'd0);
        if (!flush && a_v) begin
            if (b_v && !same_reg) begin
                gnt[a] = 1'b1;
                gnt[b] = 1'b1;
                p1_v   = 1'b1;
                p2_v   = 1'b1;
                p1     = a_older ? a : b;
                p2     = a_older ? b : a;
                last   = b;
            end else if (b_v) begin
                p1      = a_older ? a : b;
                gnt[p1] = 1'b1;
                p1_v    = 1'b1;
                last    = p1;
            end else begin
                gnt[a] = 1'b1;
                p1_v   = 1'b1;
                p1     = a;
                last   = a;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            pop[s]  = gnt[s] && !cand_byp[s];
            push[s] = bus.src_valid[s] && ready[s] && !flush && !(gnt[s] && cand_byp[s]);
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                mem[s][wr_ptr[s]] <= in_ent[s];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
            rr_ptr        <= 2'd0;
            bus.WE1       <= 1'b0;
            bus.WriteReg1 <= 5'd0;
            bus.ResultW1  <= 32'd0;
            bus.WE2       <= 1'b0;
            bus.WriteReg2 <= 5'd0;
            bus.ResultW2  <= 32'd0;
        end else if (flush) begin
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
            rr_ptr  <= 2'd0;
            bus.WE1 <= 1'b0;
            bus.WE2 <= 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr[s] <= wr_ptr[s] + PW'(push[s]);
                rd_ptr[s] <= rd_ptr[s] + PW'(pop[s]);
                count[s]  <= count[s] + (PW+1)'(push[s]) - (PW+1)'(pop[s]);
            end
            if (|gnt) begin
                rr_ptr <= inc3(last);
            end
            // r0 still takes its slot and pops, but never asserts a write enable
            bus.WE1 <= p1_v && (cand[p1].rd != 5'd0);
            bus.WE2 <= p2_v && (cand[p2].rd != 5'd0);
            if (p1_v) begin
                bus.WriteReg1 <= cand[p1].rd;
                bus.ResultW1  <= cand[p1].data;
            end
            if (p2_v) begin
                bus.WriteReg2 <= cand[p2].rd;
                bus.ResultW2  <= cand[p2].data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed bench for wb_port_arbiter against a queue-based model
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.DEPTH(DEPTH), .NSRC(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tag;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q [3][$];
    int          m_rr = 0;
    bit          e_we1 = 0, e_we2 = 0;
    logic [4:0]  e_reg1 = '0, e_reg2 = '0;
    logic [31:0] e_d1 = '0, e_d2 = '0;

    bit          v_in [3];
    ent_t        in_e [3];
    int          checks = 0;
    int          failures = 0;
    int unsigned tcount = 100;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        return (q[0].size() != 0) || (q[1].size() != 0) || (q[2].size() != 0);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) q[s].delete();
        m_rr  = 0;
        e_we1 = 0;
        e_we2 = 0;
    endtask

    // One clock of the arbiter, computed from the scheduling rules on plain queues
    task automatic model_step();
        bit   cv [3];
        bit   cb [3];
        bit   used [3];
        bit   rdy [3];
        ent_t ce [3];
        int   ord [$];
        int   g1, g2, ng, last, a, b;
        g1 = 0; g2 = 0; ng = 0; last = 0;
        for (int s = 0; s < 3; s++) begin
            rdy[s]  = q[s].size() < DEPTH;
            cv[s]   = 0;
            cb[s]   = 0;
            used[s] = 0;
            ce[s]   = in_e[s];
            if (q[s].size() != 0) begin
                cv[s] = 1;
                ce[s] = q[s][0];
            end
`ifdef WBARB_BYPASS_EN
            else if (v_in[s] && !flush) begin
                cv[s] = 1;
                cb[s] = 1;
            end
`endif
        end
        e_we1 = 0;
        e_we2 = 0;
        if (!flush) begin
            for (int k = 0; k < 3; k++) begin
                if (cv[(m_rr + k) % 3]) ord.push_back((m_rr + k) % 3);
            end
            if (ord.size() >= 2) begin
                a = ord[0];
                b = ord[1];
                if (ce[a].rd == ce[b].rd && ce[a].rd != 0) begin
                    g1 = (ce[a].tag < ce[b].tag) ? a : b;
                    ng = 1;
                    last = g1;
                end else begin
                    g1 = (ce[a].tag < ce[b].tag) ? a : b;
                    g2 = (g1 == a) ? b : a;
                    ng = 2;
                    last = b;
                end
            end else if (ord.size() == 1) begin
                g1 = ord[0];
                ng = 1;
                last = g1;
            end
            if (ng > 0) m_rr = (last + 1) % 3;
            if (ng >= 1) begin
                e_we1  = ce[g1].rd != 0;
                e_reg1 = ce[g1].rd;
                e_d1   = ce[g1].data;
                if (cb[g1]) used[g1] = 1; else void'(q[g1].pop_front());
            end
            if (ng == 2) begin
                e_we2  = ce[g2].rd != 0;
                e_reg2 = ce[g2].rd;
                e_d2   = ce[g2].data;
                if (cb[g2]) used[g2] = 1; else void'(q[g2].pop_front());
            end
        end
        for (int s = 0; s < 3; s++) begin
            if (v_in[s] && rdy[s] && !flush && !used[s]) q[s].push_back(in_e[s]);
        end
        if (flush) model_reset();
    endtask

    task automatic apply();
        for (int s = 0; s < 3; s++) begin
            bus.src_valid[s]         = v_in[s];
            bus.src_tag[s*32 +: 32]  = in_e[s].tag;
            bus.src_reg[s*5 +: 5]    = in_e[s].rd;
            bus.src_data[s*32 +: 32] = in_e[s].data;
        end
    endtask

    task automatic step();
        apply();
        #0;
        for (int s = 0; s < 3; s++) check("src_ready", bus.src_ready[s], q[s].size() < DEPTH);
        check("busy", busy, model_busy());
        model_step();
        @(posedge clk);
        #1;
        check("WE1", bus.WE1, e_we1);
        check("WE2", bus.WE2, e_we2);
        if (e_we1) begin
            check("WriteReg1", bus.WriteReg1, e_reg1);
            check("ResultW1", bus.ResultW1, e_d1);
        end
        if (e_we2) begin
            check("WriteReg2", bus.WriteReg2, e_reg2);
            check("ResultW2", bus.ResultW2, e_d2);
        end
    endtask

    task automatic idle();
        for (int s = 0; s < 3; s++) v_in[s] = 0;
    endtask

    task automatic put(input int s, input logic [31:0] tag, input logic [4:0] rd, input logic [31:0] data);
        v_in[s]      = 1;
        in_e[s].tag  = tag;
        in_e[s].rd   = rd;
        in_e[s].data = data;
    endtask

    task automatic rand_cycle(input int vpct, input int flush_inv);
        int rot;
        rot = $urandom_range(0, 2);
        for (int s = 0; s < 3; s++) begin
            if ($urandom_range(0, 99) < vpct) put(s, tcount * 3 + (s + rot) % 3, 5'($urandom_range(0, 3)), $urandom);
            else v_in[s] = 0;
        end
        tcount++;
        flush = (flush_inv > 0) && ($urandom_range(0, flush_inv - 1) == 0);
        step();
        flush = 0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while (n < 60 && model_busy()) begin
            step();
            n++;
        end
        step();
        step();
        check("drain_busy", busy, 0);
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        step();
        flush = 0;
    endtask

    initial begin
        bit saw_full;
        idle();
        for (int s = 0; s < 3; s++) put(s, 0, 0, 0);
        idle();
        apply();
        #2;
        check("rst_WE1", bus.WE1, 0);
        check("rst_WE2", bus.WE2, 0);
        check("rst_WriteReg1", bus.WriteReg1, 0);
        check("rst_ResultW2", bus.ResultW2, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check("ready_after_rst", bus.src_ready, 3'b111);

        // single result from src0
        put(0, 5, 3, 32'hAA);
        step();
        idle();
`ifdef WBARB_BYPASS_EN
        check("single_early_WE1", bus.WE1, 1);
        check("single_early_reg", bus.WriteReg1, 3);
`else
        check("single_early_WE1", bus.WE1, 0);
        step();
        check("single_WE1", bus.WE1, 1);
        check("single_reg", bus.WriteReg1, 3);
        check("single_data", bus.ResultW1, 32'hAA);
        check("single_WE2", bus.WE2, 0);
`endif
        drain();

        // three simultaneous results from rr_ptr = 0
        do_flush();
        put(0, 10, 1, 32'h11);
        put(1, 8, 2, 32'h22);
        put(2, 9, 4, 32'h44);
        step();
        idle();
`ifndef WBARB_BYPASS_EN
        step();
`endif
        check("three_p1", bus.WriteReg1, 2);
        check("three_p2", bus.WriteReg2, 1);
        check("three_we2", bus.WE2, 1);
        step();
        check("three_next_p1", bus.WriteReg1, 4);
        check("three_next_we2", bus.WE2, 0);
        drain();

        // same-register conflict, older tag first
        do_flush();
        put(0, 20, 7, 32'd1);
        put(2, 15, 7, 32'd2);
        step();
        idle();
`ifndef WBARB_BYPASS_EN
        step();
`endif
        check("conf_k_data", bus.ResultW1, 2);
        check("conf_k_we2", bus.WE2, 0);
        step();
        check("conf_k1_data", bus.ResultW1, 1);
        check("conf_k1_reg", bus.WriteReg1, 7);
        drain();

        // backpressure: all on one register so only one write per cycle drains
        saw_full = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            for (int s = 0; s < 3; s++) put(s, tcount * 3 + s, 7, $urandom);
            tcount++;
            step();
            if (!bus.src_ready[1]) saw_full = 1;
        end
        check("bp_src1_full", saw_full, 1);
        drain();

        // r0 write pops without enabling a port
        put(2, tcount * 3, 0, 32'hFF);
        tcount++;
        step();
        idle();
        step();
        check("r0_WE1", bus.WE1, 0);
        step();
        check("r0_WE1_late", bus.WE1, 0);
        check("r0_busy", busy, 0);

        // randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) rand_cycle(60, 50);
        drain();

        // flush with full FIFOs
        for (int c = 0; c < DEPTH + 2; c++) begin
            for (int s = 0; s < 3; s++) put(s, tcount * 3 + s, 9, $urandom);
            tcount++;
            step();
        end
        do_flush();
        check("flush_busy", busy, 0);
        for (int c = 0; c < 3; c++) step();

        // async reset in the middle of a burst
        for (int c = 0; c < 4; c++) rand_cycle(90, 0);
        idle();
        apply();
        #2;
        rst = 1;
        #1;
        check("arst_WE1", bus.WE1, 0);
        check("arst_WE2", bus.WE2, 0);
        check("arst_ResultW1", bus.ResultW1, 0);
        check("arst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check("arst_ready", bus.src_ready, 3'b111);
        for (int c = 0; c < 100; c++) rand_cycle(50, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
